keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 matrix keypad. It drives the columns one at a time, samples the synchronized rows and detects a press. It then sequences a press/release debounce on the pressed key and emits one registered key code per debounced press. It sits between the keypad pins and the display/key-handling logic, and replaces free-running column drive plus a separate debouncer.

Parameters:
SCAN_CYCLES, 48000, clk cycles each column is driven (1 ms at 48 MHz); must be >= 2
DEBOUNCE_CYCLES, 960000, clk cycles of each debounce window (20 ms at 48 MHz); must be >= 2
REPEAT_CYCLES, 24000000, auto-repeat period in clk cycles; used only when KEYPAD_REPEAT_EN is defined

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rows  input  4  keypad rows, active-low, asynchronous to clk
cols  output  4  column drive, active-low, one-hot-low
key_code  output  4  last debounced key, code = row_idx*4 + col_idx
key_valid  output  1  one-cycle pulse when key_code updates
key_held  output  1  high while a debounced key is held

Behaviour:
- Reset (async, active-high), all registers:
  - state=SCAN, col_idx=0, cols=4'b1110
  - key_code=4'h0, key_valid=0, key_held=0
  - timer=0, row synchronizer=4'b1111
- rows pass through a 2-flop synchronizer (rows_s) before any use.
- cols = ~(4'b0001 << col_idx) at all times; col_idx changes only in SCAN, or on the DEBOUNCE_DN->SCAN and DEBOUNCE_UP->SCAN transitions.
- One timer, width $clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES)). It is cleared on every state change and increments in every other cycle. "timer end" means timer == limit-1.
- SCAN:
  - At SCAN timer end, if rows_s == 4'b1111: col_idx <= col_idx+1 (wraps 3->0), timer cleared, stay in SCAN.
  - At SCAN timer end, if rows_s != 4'b1111: latch row_idx = lowest index with rows_s[i]==0, latch col_idx (frozen), go to DEBOUNCE_DN.
  - rows_s is ignored before timer end; this gives settle time.
- DEBOUNCE_DN, at timer end:
  - rows_s[row_idx]==0: go to HELD; key_code <= row_idx*4+col_idx; key_valid=1 for exactly that one cycle.
  - Otherwise: go to SCAN with col_idx+1.
- HELD:
  - key_held=1.
  - rows_s[row_idx]==1 -> DEBOUNCE_UP.
  - Other rows in the frozen column are ignored. Other columns are not driven, so other keys are invisible.
- DEBOUNCE_UP, at timer end:
  - rows_s[row_idx]==1: go to SCAN with col_idx+1; key_held=0.
  - Otherwise: return to HELD with no new key_valid.
- key_held is 1 in HELD and DEBOUNCE_UP, 0 otherwise.
- key_code holds its value until the next key_valid; it is never cleared by release.
- Latency: key_valid asserts DEBOUNCE_CYCLES cycles after entry to DEBOUNCE_DN, plus 2 synchronizer cycles after the pin edge.
- Reset asserted mid-debounce or mid-hold: immediate return to reset values with no key_valid. The first scan after reset starts at col 0.
- Unused state encodings return to SCAN.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: in HELD a second counter runs. Each time it reaches REPEAT_CYCLES-1, key_valid pulses for one cycle (key_code unchanged) and the counter restarts. The counter is cleared on entry to HELD and while in DEBOUNCE_UP.
- Undefined: no repeat counter exists; exactly one key_valid per debounced press.

Test Plan:
All scenarios use SCAN_CYCLES=4 and DEBOUNCE_CYCLES=8.
- Reset, rows=1111 for 40 cycles -> cols cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid never asserts.
- Key row 2 / col 1 pressed (rows=1011 while cols=1101) and held 30 cycles -> cols frozen at 1101; one key_valid pulse with key_code=4'h9; key_held=1.
- Press lasting 3 cycles (bounce) -> DEBOUNCE_DN expires with row high; no key_valid; scanning resumes at col 2.
- Release glitch during DEBOUNCE_UP (row high 3 cycles, then low) -> return to HELD; no second key_valid; key_held stays 1.
- Rows 1 and 3 low together in col 0 -> key_code=4'h4 (lowest row wins).
- Assert reset during DEBOUNCE_DN -> cols=1110, key_held=0, key_code=0 immediately (asynchronous); no key_valid.

Source files
------------

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and key-event bundle for keypad_scan_ctrl.
// master: the scan controller; slave: the keypad/consumer side.
interface keypad_scan_ctrl_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  rows,
    output cols, key_code, key_valid, key_held
  );

  modport slave (
    output rows,
    input  cols, key_code, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with press/release debounce and one key_valid per press.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
  parameter int SCAN_CYCLES     = 48000,
  parameter int DEBOUNCE_CYCLES = 960000,
  parameter int REPEAT_CYCLES   = 24000000
) (
  input  logic               clk,
  input  logic               reset,
  keypad_scan_ctrl_if.master kp
);

  localparam int TMAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] SCAN_END = TW'(SCAN_CYCLES - 1);
  localparam logic [TW-1:0] DEB_END  = TW'(DEBOUNCE_CYCLES - 1);

  // Both windows need at least one settle cycle plus the decision cycle.
  if (SCAN_CYCLES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("keypad_scan_ctrl: SCAN/DEBOUNCE/REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEBOUNCE_DN = 2'd1,
    HELD        = 2'd2,
    DEBOUNCE_UP = 2'd3
  } state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [1:0]    col_idx_reg;
  logic [1:0]    row_idx_reg;
  logic [3:0]    rows_meta_reg;
  logic [3:0]    rows_s_reg;
  logic [3:0]    key_code_reg;
  logic          key_valid_reg;
  logic          key_held_reg;
  logic [1:0]    low_row;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] RPT_END = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt_reg;
`endif

  // Lowest-numbered active row wins when several are pressed in one column.
  always_comb begin
    low_row = 2'd3;
    if (!rows_s_reg[2]) low_row = 2'd2;
    if (!rows_s_reg[1]) low_row = 2'd1;
    if (!rows_s_reg[0]) low_row = 2'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= SCAN;
      timer_reg     <= '0;
      col_idx_reg   <= 2'd0;
      row_idx_reg   <= 2'd0;
      rows_meta_reg <= 4'b1111;
      rows_s_reg    <= 4'b1111;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_reg       <= '0;
`endif
    end else begin
      rows_meta_reg <= kp.rows;
      rows_s_reg    <= rows_meta_reg;
      key_valid_reg <= 1'b0;
      timer_reg     <= timer_reg + 1'b1;
      case (state_reg)
        SCAN: begin
          if (timer_reg == SCAN_END) begin
            timer_reg <= '0;
            if (rows_s_reg == 4'b1111) begin
              col_idx_reg <= col_idx_reg + 2'd1;
            end else begin
              row_idx_reg <= low_row;
              state_reg   <= DEBOUNCE_DN;
            end
          end
        end
        DEBOUNCE_DN: begin
          if (timer_reg == DEB_END) begin
            timer_reg <= '0;
            if (!rows_s_reg[row_idx_reg]) begin
              state_reg     <= HELD;
              key_code_reg  <= {row_idx_reg, col_idx_reg};
              key_valid_reg <= 1'b1;
              key_held_reg  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rpt_reg       <= '0;
`endif
            end else begin
              state_reg   <= SCAN;
              col_idx_reg <= col_idx_reg + 2'd1;
            end
          end
        end
        HELD: begin
          if (rows_s_reg[row_idx_reg]) begin
            state_reg <= DEBOUNCE_UP;
            timer_reg <= '0;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rpt_reg == RPT_END) begin
            rpt_reg       <= '0;
            key_valid_reg <= 1'b1;
          end else begin
            rpt_reg <= rpt_reg + 1'b1;
          end
`endif
        end
        DEBOUNCE_UP: begin
`ifdef KEYPAD_REPEAT_EN
          rpt_reg <= '0;
`endif
          if (timer_reg == DEB_END) begin
            timer_reg <= '0;
            if (rows_s_reg[row_idx_reg]) begin
              state_reg    <= SCAN;
              col_idx_reg  <= col_idx_reg + 2'd1;
              key_held_reg <= 1'b0;
            end else begin
              state_reg <= HELD;
            end
          end
        end
        default: begin
          state_reg    <= SCAN;
          timer_reg    <= '0;
          key_held_reg <= 1'b0;
        end
      endcase
    end
  end

  assign kp.cols      = ~(4'b0001 << col_idx_reg);
  assign kp.key_code  = key_code_reg;
  assign kp.key_valid = key_valid_reg;
  assign kp.key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical keypad model drives rows from cols,
// a scoreboard queue holds expected key codes, and one monitor does all compares.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c is down

  int checks = 0;
  int errors = 0;
  int exp_cols = -1;
  int exp_held = -1;
  int exp_key = -1;
  int exp_kv = -1;
  bit chk_empty = 1'b0;
  int sb[$];

  keypad_scan_ctrl_if kif ();

  keypad_scan_ctrl #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kif)
  );

  always #5 clk = ~clk;

  // A row reads low when any pressed key in it sits on a driven (low) column.
  always_comb begin
    kif.rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.cols[c]) kif.rows[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (exp_cols >= 0) begin
      checks++;
      if (kif.cols !== 4'(exp_cols)) begin
        errors++;
        $display("FAIL cols: got %b expected %b at %0t", kif.cols, 4'(exp_cols), $time);
      end
    end
    if (exp_held >= 0) begin
      checks++;
      if (kif.key_held !== 1'(exp_held)) begin
        errors++;
        $display("FAIL key_held: got %b expected %0d at %0t", kif.key_held, exp_held, $time);
      end
    end
    if (exp_key >= 0) begin
      checks++;
      if (kif.key_code !== 4'(exp_key)) begin
        errors++;
        $display("FAIL key_code: got %h expected %h at %0t", kif.key_code, 4'(exp_key), $time);
      end
    end
    if (exp_kv >= 0) begin
      checks++;
      if (kif.key_valid !== 1'(exp_kv)) begin
        errors++;
        $display("FAIL key_valid_timing: got %b expected %0d at %0t", kif.key_valid, exp_kv, $time);
      end
    end
    if (!reset && kif.key_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key_valid: got code %h expected no event at %0t", kif.key_code, $time);
      end else begin
        int e;
        e = sb.pop_front();
        $display("key event: code %h expected %h at %0t", kif.key_code, 4'(e), $time);
        if (kif.key_code !== 4'(e)) begin
          errors++;
          $display("FAIL scoreboard_code: got %h expected %h", kif.key_code, 4'(e));
        end
      end
    end
    if (chk_empty) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL missing_key_valid: got %0d pending expected 0", sb.size());
      end
    end
  end

  task automatic set_exp(input int c, input int h, input int k, input int v);
    exp_cols = c;
    exp_held = h;
    exp_key  = k;
    exp_kv   = v;
  endtask

  task automatic tick(input int c, input int h, input int k, input int v);
    @(posedge clk);
    #1;
    set_exp(c, h, k, v);
  endtask

  // Idle scan pattern n clock edges after reset release: column (n/4)%4 driven low.
  function automatic int colpat(input int n);
    int i;
    i = (n / 4) % 4;
    return (~(1 << i)) & 15;
  endfunction

  task automatic start();
    set_exp(-1, -1, -1, -1);
    pressed = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    set_exp(14, 0, 0, 0);
  endtask

  initial begin
    // Idle scan: columns rotate every 4 cycles, no key events.
    start();
    for (int n = 1; n <= 40; n++) tick(colpat(n), 0, 0, 0);

    // Key row 2 / col 1: detected at edge 8, valid exactly 8 cycles later.
    start();
    pressed[9] = 1'b1;
    sb.push_back(9);
    for (int n = 1; n <= 45; n++)
      tick(n < 4 ? 14 : 13, n >= 16 ? 1 : 0, n >= 16 ? 9 : 0, n == 16 ? 1 : 0);
    pressed = '0;
    for (int n = 46; n <= 65; n++)
      tick(n < 56 ? 13 : n < 60 ? 11 : n < 64 ? 7 : 14, n < 56 ? 1 : 0, 9, 0);

    // 3-cycle bounce in col 1: debounce fails, scanning resumes at col 2.
    start();
    for (int n = 1; n <= 24; n++) begin
      tick(n < 4 ? 14 : n < 16 ? 13 : n < 20 ? 11 : n < 24 ? 7 : 14, 0, 0, 0);
      if (n == 5) pressed[1] = 1'b1;
      if (n == 8) pressed = '0;
    end

    // Release glitch while held on key 15: back to HELD, no second event.
    start();
    pressed[15] = 1'b1;
    sb.push_back(15);
    for (int n = 1; n <= 50; n++) begin
      tick(n < 12 ? colpat(n) : 7, n >= 24 ? 1 : 0, n >= 24 ? 15 : 0, n == 24 ? 1 : 0);
      if (n == 30) pressed = '0;
      if (n == 32) pressed[15] = 1'b1;
    end
    pressed = '0;
    for (int n = 51; n <= 70; n++) tick(-1, n == 70 ? 0 : -1, 15, -1);

    // Rows 1 and 3 together in col 0: lowest row gives code 4.
    start();
    pressed[4] = 1'b1;
    pressed[12] = 1'b1;
    sb.push_back(4);
    for (int n = 1; n <= 30; n++)
      tick(14, n >= 12 ? 1 : 0, n >= 12 ? 4 : 0, n == 12 ? 1 : 0);
    pressed = '0;
    for (int n = 31; n <= 50; n++) tick(-1, n == 50 ? 0 : -1, 4, -1);

    // Press key 11, release, then press key 14 and reset it mid-debounce.
    start();
    pressed[11] = 1'b1;
    sb.push_back(11);
    for (int n = 1; n <= 30; n++)
      tick(n < 12 ? colpat(n) : 7, n >= 24 ? 1 : 0, n >= 24 ? 11 : 0, n == 24 ? 1 : 0);
    pressed = '0;
    for (int n = 31; n <= 55; n++) begin
      tick(n < 41 ? 7 : n < 45 ? 14 : n < 49 ? 13 : 11, n < 41 ? 1 : 0, 11, 0);
      if (n == 41) pressed[14] = 1'b1;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    set_exp(14, 0, 0, 0);
    tick(14, 0, 0, 0);
    pressed = '0;
    start();
    for (int n = 1; n <= 8; n++) tick(colpat(n), 0, 0, 0);

    // Randomized presses, some multi-row, odd iterations add a release glitch.
    start();
    for (int it = 0; it < 12; it++) begin
      int c;
      int mask;
      int code;
      int hold;
      int idle;
      c = int'($urandom_range(0, 3));
      mask = int'($urandom_range(1, 15));
      code = -1;
      pressed = '0;
      for (int r = 0; r < 4; r++) begin
        if (mask[r]) begin
          pressed[r*4+c] = 1'b1;
          if (code < 0) code = r * 4 + c;
        end
      end
      sb.push_back(code);
      hold = int'($urandom_range(35, 55));
      for (int i = 1; i <= hold; i++) tick(-1, i == hold ? 1 : -1, i == hold ? code : -1, -1);
      if (it % 2 == 1) begin
        logic [15:0] keep;
        keep = pressed;
        pressed = '0;
        for (int i = 0; i < 3; i++) tick(-1, 1, code, -1);
        pressed = keep;
        for (int i = 0; i < 12; i++) tick(-1, 1, code, -1);
      end
      pressed = '0;
      idle = int'($urandom_range(20, 30));
      for (int i = 1; i <= idle; i++) tick(-1, i == idle ? 0 : -1, i == idle ? code : -1, -1);
    end

    tick(-1, -1, -1, -1);
    chk_empty = 1'b1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
